// File: rtl/cmd_seq_pkg.sv
// cmd_sequencer shared types: FSM states, command opcodes and FIFO entry.
// Used by cmd_fifo and cmd_sequencer.
package cmd_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RUN,
    DRAIN
  } state_e;

  localparam logic [1:0] OP_NOP   = 2'd0;
  localparam logic [1:0] OP_ENUM  = 2'd1;
  localparam logic [1:0] OP_COUNT = 2'd2;
  localparam logic [1:0] OP_UPD   = 2'd3;

  typedef struct packed {
    logic [1:0] op;
    logic [7:0] data;
    logic [3:0] hold;
  } cmd_entry_t;

  function automatic logic is_nop(cmd_entry_t e);
    return e.op == OP_NOP;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// cmd_fifo: synchronous command FIFO, DEPTH entries (power of two).
// No same-cycle bypass; head is valid whenever the FIFO is not empty.
import cmd_seq_pkg::*;

module cmd_fifo #(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  cmd_entry_t    din_i,
  input  logic          pop_i,
  output cmd_entry_t    dout_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [LW-1:0] level_o
);

  cmd_entry_t    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full_o  = cnt_q == LW'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign level_o = cnt_q;
  assign dout_o  = mem_q[rptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointer and occupancy next-state.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (do_push) wptr_d = wptr_q + AW'(1);
    if (do_pop)  rptr_d = rptr_q + AW'(1);
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + LW'(1);
      2'b01:   cnt_d = cnt_q - LW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and occupancy registers; reset flushes the FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage array, written on accepted push only.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= din_i;
  end

endmodule

// File: rtl/cmd_sequencer.sv
// cmd_sequencer: issues buffered host commands to the mode controller.
// Optional acknowledge timeout: define CMD_SEQ_TIMEOUT_EN.
import cmd_seq_pkg::*;

module cmd_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [1:0]                 cmd_op,
  input  logic [7:0]                 cmd_data,
  input  logic [3:0]                 cmd_hold,
  input  logic [1:0]                 regime,
  output logic [7:0]                 x,
  output logic [1:0]                 on,
  output logic                       start,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       err
);

  state_e     state_q, state_d;
  logic [7:0] x_q, x_d;
  logic [1:0] on_q, on_d;
  logic       start_q, start_d;
  logic [3:0] timer_q, timer_d;
  logic [1:0] op_q, op_d;
  logic [3:0] hold_q, hold_d;
  logic       pop, full, empty;
  cmd_entry_t din, head;

`ifdef CMD_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          err_q, err_d;
`endif

  assign din = '{op: cmd_op, data: cmd_data, hold: cmd_hold};

  cmd_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (cmd_valid),
    .din_i  (din),
    .pop_i  (pop),
    .dout_o (head),
    .full_o (full),
    .empty_o(empty),
    .level_o(level)
  );

  assign cmd_ready = !full;
  assign busy      = state_q != IDLE;
  assign x         = x_q;
  assign on        = on_q;
  assign start     = start_q;

`ifdef CMD_SEQ_TIMEOUT_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // Next-state, pop decision and output register updates.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    on_d    = on_q;
    start_d = start_q;
    timer_d = timer_q;
    op_d    = op_q;
    hold_d  = hold_q;
    pop     = 1'b0;
`ifdef CMD_SEQ_TIMEOUT_EN
    tcnt_d  = tcnt_q;
    err_d   = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (!empty && regime == 2'd0) begin
          pop = 1'b1;
          if (!is_nop(head)) begin
            on_d    = head.op;
            x_d     = head.data;
            op_d    = head.op;
            hold_d  = head.hold;
            state_d = ISSUE;
`ifdef CMD_SEQ_TIMEOUT_EN
            tcnt_d  = '0;
`endif
          end
        end
      end
      ISSUE: begin
        if (regime == op_q) begin
          on_d = 2'd0;
          if (hold_q == 4'd0) begin
            start_d = 1'b0;
            state_d = DRAIN;
          end else begin
            start_d = 1'b1;
            timer_d = hold_q - 4'd1;
            state_d = RUN;
          end
        end
`ifdef CMD_SEQ_TIMEOUT_EN
        else if (tcnt_q == TW'(TIMEOUT - 1)) begin
          on_d    = 2'd0;
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
`endif
      end
      RUN: begin
        if (timer_q == 4'd0) begin
          start_d = 1'b0;
          state_d = DRAIN;
        end else begin
          timer_d = timer_q - 4'd1;
        end
      end
      DRAIN: begin
        if (regime == 2'd0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Output, timer and latched-command registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q     <= '0;
      on_q    <= '0;
      start_q <= 1'b0;
      timer_q <= '0;
      op_q    <= '0;
      hold_q  <= '0;
`ifdef CMD_SEQ_TIMEOUT_EN
      tcnt_q  <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      x_q     <= x_d;
      on_q    <= on_d;
      start_q <= start_d;
      timer_q <= timer_d;
      op_q    <= op_d;
      hold_q  <= hold_d;
`ifdef CMD_SEQ_TIMEOUT_EN
      tcnt_q  <= tcnt_d;
      err_q   <= err_d;
`endif
    end
  end

endmodule
